// File: rtl/fnorm_rnd_pkg.sv
// Shared FMA definitions: rounding-mode encoding, flag bit positions and the
// normalize/round stage beat structures.
package fnorm_rnd_pkg;

   localparam int MAG_W = 82;
   localparam int LZC_W = 7;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;

   localparam int FLG_NV = 4;
   localparam int FLG_DZ = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   typedef struct packed {
      logic              sign;
      logic signed [9:0] exp;
      logic [MAG_W-1:0]  mag;
      rm_e               rm;
      logic              spc;
      logic [31:0]       spc_val;
      logic [4:0]        spc_flag;
   } normit;

   typedef struct packed {
      logic [31:0] rslt;
      logic [4:0]  flag;
   } normot;

   // Normalized beat held between the shift stage and the round stage.
   typedef struct packed {
      logic             sign;
      rm_e              rm;
      logic             spc;
      logic [31:0]      spc_val;
      logic [4:0]       spc_flag;
      logic             zero;
      logic             tiny;
      logic             sticky;
      logic [10:0]      exp_b;
      logic [MAG_W-1:0] norm;
   } norm_s1_t;

endpackage

// File: rtl/fnorm_rnd_lzc82.sv
// Combinational leading-zero counter for the 82-bit adder magnitude.
module lzc82
   import fnorm_rnd_pkg::*;
(
   input  logic [MAG_W-1:0] din,
   output logic [LZC_W-1:0] cnt,
   output logic             zero
);

   always_comb begin
      cnt = LZC_W'(MAG_W);
      for (int i = 0; i < MAG_W; i++) begin
         if (din[i]) cnt = LZC_W'(MAG_W - 1 - i);
      end
   end

   assign zero = ~|din;

endmodule

// File: rtl/fnorm_rnd.sv
// Two-stage FMA back end: normalize the adder magnitude, then round and pack
// an IEEE single result with exception flags. Elastic valid/ready pipeline.
module fnorm_rnd
   import fnorm_rnd_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic signed [9:0] in_exp,
   input  logic [81:0]       in_mag,
   input  logic [2:0]        in_rm,
   input  logic              in_spc,
   input  logic [31:0]       in_spc_val,
   input  logic [4:0]        in_spc_flag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       rslt,
   output logic [4:0]        flag
);

   function automatic logic round_up(input rm_e rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
      case (rm)
         RM_RNE:  return g & (s | lsb);
         RM_RDN:  return (g | s) & sign;
         RM_RUP:  return (g | s) & ~sign;
         RM_RMM:  return g;
         default: return 1'b0;
      endcase
   endfunction

   // Overflow saturates to Inf or to the largest finite value depending on direction.
   function automatic logic [31:0] ovf_word(input rm_e rm, input logic sign);
      logic to_inf;
      case (rm)
         RM_RNE, RM_RMM: to_inf = 1'b1;
         RM_RUP:         to_inf = ~sign;
         RM_RDN:         to_inf = sign;
         default:        to_inf = 1'b0;
      endcase
      return to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
   endfunction

   normit                     beat_p0;
   logic [LZC_W-1:0]          lz_p0;
   logic                      zero_p0;
   logic signed [11:0]        e_p0;
   logic [LZC_W-1:0]          sh_p0;
   logic [MAG_W-1:0]          just_p0;
   logic [MAG_W-1:0]          mask_p0;
   norm_s1_t                  s1_p0;
   norm_s1_t                  s1_p1;
   logic                      vld_p1;
   logic                      vld_p2;
   logic                      adv_p1;
   normot                     res_p1;
   normot                     res_p2;

   assign beat_p0 = '{sign: in_sign, exp: in_exp, mag: in_mag, rm: rm_e'(in_rm),
                      spc: in_spc, spc_val: in_spc_val, spc_flag: in_spc_flag};

   lzc82 u_lzc (
      .din  (beat_p0.mag),
      .cnt  (lz_p0),
      .zero (zero_p0)
   );

   // ---- S1: leading-one exponent, left-justify, denormalizing right shift ----
   always_comb begin
      // Leading one at p = 81 - lz, so e = exp + p - 80 = exp + 1 - lz.
      e_p0    = {{2{beat_p0.exp[9]}}, beat_p0.exp} + 12'sd1 - $signed({5'd0, lz_p0});
      just_p0 = beat_p0.mag << lz_p0;
      sh_p0   = '0;
      mask_p0 = '0;
      s1_p0.sign     = beat_p0.sign;
      s1_p0.rm       = beat_p0.rm;
      s1_p0.spc      = beat_p0.spc;
      s1_p0.spc_val  = beat_p0.spc_val;
      s1_p0.spc_flag = beat_p0.spc_flag;
      s1_p0.zero     = zero_p0;
      if (e_p0 <= 12'sd0) begin
         sh_p0   = (e_p0 < -12'sd80) ? LZC_W'(MAG_W) : LZC_W'(12'sd1 - e_p0);
         mask_p0 = ~({MAG_W{1'b1}} << sh_p0);
         s1_p0.norm   = just_p0 >> sh_p0;
         s1_p0.sticky = |(just_p0 & mask_p0);
         s1_p0.exp_b  = '0;
         s1_p0.tiny   = 1'b1;
      end else begin
         s1_p0.norm   = just_p0;
         s1_p0.sticky = 1'b0;
         s1_p0.exp_b  = 11'(e_p0);
         s1_p0.tiny   = 1'b0;
      end
   end

   assign adv_p1   = vld_p1 & (~vld_p2 | out_ready);
   assign in_ready = ~vld_p1 | adv_p1;

   always_ff @(posedge clk) begin
      if (in_valid && in_ready) s1_p1 <= s1_p0;
   end

   // ---- S2: round, renormalize, overflow/underflow, pack ----
   logic [23:0] sig_p1;
   logic        g_p1, s_p1, up_p1, nx_p1;
   logic [24:0] sum_p1;
   logic [10:0] expr_p1;
   logic [22:0] frac_p1;

   always_comb begin
      sig_p1 = s1_p1.norm[81:58];
      g_p1   = s1_p1.norm[57];
      s_p1   = (|s1_p1.norm[56:0]) | s1_p1.sticky;
      up_p1  = round_up(s1_p1.rm, s1_p1.sign, sig_p1[0], g_p1, s_p1);
      nx_p1  = g_p1 | s_p1;
      sum_p1 = {1'b0, sig_p1} + 25'(up_p1);
      if (s1_p1.exp_b == '0) begin
         // A subnormal that rounds up to 0x800000 becomes the smallest normal.
         expr_p1 = {10'd0, sum_p1[23]};
         frac_p1 = sum_p1[22:0];
      end else if (sum_p1[24]) begin
         expr_p1 = s1_p1.exp_b + 11'd1;
         frac_p1 = sum_p1[23:1];
      end else begin
         expr_p1 = s1_p1.exp_b;
         frac_p1 = sum_p1[22:0];
      end
      res_p1 = '0;
      if (s1_p1.spc) begin
         res_p1.rslt = s1_p1.spc_val;
         res_p1.flag = s1_p1.spc_flag;
      end else if (s1_p1.zero) begin
         res_p1.rslt = {s1_p1.sign, 31'd0};
      end else if (expr_p1 >= 11'd255) begin
         res_p1.rslt         = ovf_word(s1_p1.rm, s1_p1.sign);
         res_p1.flag[FLG_OF] = 1'b1;
         res_p1.flag[FLG_NX] = 1'b1;
      end else begin
         res_p1.rslt         = {s1_p1.sign, expr_p1[7:0], frac_p1};
         res_p1.flag[FLG_UF] = s1_p1.tiny & nx_p1;
         res_p1.flag[FLG_NX] = nx_p1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         res_p2 <= '0;
      end else begin
         if (in_ready) vld_p1 <= in_valid;
         if (~vld_p2 | out_ready) vld_p2 <= vld_p1;
         if (adv_p1) res_p2 <= res_p1;
      end
   end

   assign out_valid = vld_p2;
   assign rslt      = res_p2.rslt;
   assign flag      = res_p2.flag;

endmodule

// File: tb/tb_fnorm_rnd.sv
// Scoreboard bench for fnorm_rnd: directed beats with hand-computed results,
// backpressure, and reset while beats are in flight.
module tb_fnorm_rnd;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_sign = 1'b0;
   logic signed [9:0] in_exp = '0;
   logic [81:0]       in_mag = '0;
   logic [2:0]        in_rm = '0;
   logic              in_spc = 1'b0;
   logic [31:0]       in_spc_val = '0;
   logic [4:0]        in_spc_flag = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [31:0]       rslt;
   logic [4:0]        flag;

   fnorm_rnd dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sign     (in_sign),
      .in_exp      (in_exp),
      .in_mag      (in_mag),
      .in_rm       (in_rm),
      .in_spc      (in_spc),
      .in_spc_val  (in_spc_val),
      .in_spc_flag (in_spc_flag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .rslt        (rslt),
      .flag        (flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r;
      logic [4:0]  f;
      int          acc;
      bit          lat;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          hold_vld = 0;
   logic [36:0] held = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every emitted beat, checks stall stability.
   always @(negedge clk) begin
      exp_t e;
      if (reset && hold_vld && out_valid) begin
         checks++;
         if ({rslt, flag} !== held) begin
            failures++;
            $display("FAIL stall_hold actual=%0h required=%0h", {rslt, flag}, held);
         end
      end
      if (reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h/%0h required=none", rslt, flag);
         end else begin
            e = sb.pop_front();
            checks++;
            if (rslt !== e.r || flag !== e.f) begin
               failures++;
               $display("FAIL %s actual=%08h/%02h required=%08h/%02h", e.name, rslt, flag, e.r, e.f);
            end
            if (e.lat) begin
               checks++;
               if (cyc - e.acc != 2) begin
                  failures++;
                  $display("FAIL %s_latency actual=%0d required=2", e.name, cyc - e.acc);
               end
            end
         end
      end
      hold_vld = reset && out_valid && !out_ready;
      held     = {rslt, flag};
   end

   task automatic send(input string nm, input logic sg, input logic signed [9:0] ex,
                       input logic [81:0] mg, input logic [2:0] rm,
                       input logic [31:0] er, input logic [4:0] ef,
                       input bit lat = 0, input logic sp = 1'b0,
                       input logic [31:0] sv = '0, input logic [4:0] sf = '0);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mag = mg; in_rm = rm;
      in_spc = sp; in_spc_val = sv; in_spc_flag = sf;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL %s accept_timeout actual=in_ready_low required=accept", nm);
         in_valid = 1'b0;
         return;
      end
      e.r = er; e.f = ef; e.acc = cyc; e.lat = lat; e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d_pending required=0", sb.size());
         sb.delete();
      end
   endtask

   logic [81:0] m_one, m_r22, m_tie, m_ones, m_top, m_sub1, m_subn;
   bit          stale;

   initial begin
      m_one  = 82'd1 << 80;
      m_r22  = (82'h800001 << 57) | (82'd1 << 56);
      m_tie  = (82'h800000 << 57) | (82'd1 << 56);
      m_ones = (82'hFFFFFF << 57) | (82'd1 << 56);
      m_top  = 82'd1 << 81;
      m_sub1 = (82'd1 << 80) | 82'd1;
      m_subn = 82'hFFFFFF << 57;

      #12;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_rslt", 64'(rslt), 64'd0);
      chk("reset_flag", 64'(flag), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      send("one_rne",     1'b0, 10'sd127,  m_one,  3'd0, 32'h3F800000, 5'h00, 1);
      send("r22_rne",     1'b0, 10'sd127,  m_r22,  3'd0, 32'h3F800002, 5'h01);
      send("r22_rtz",     1'b0, 10'sd127,  m_r22,  3'd1, 32'h3F800001, 5'h01);
      send("r22_rup",     1'b0, 10'sd127,  m_r22,  3'd3, 32'h3F800002, 5'h01);
      send("r22_rdn_neg", 1'b1, 10'sd127,  m_r22,  3'd2, 32'hBF800002, 5'h01);
      send("r22_rmm",     1'b0, 10'sd127,  m_r22,  3'd4, 32'h3F800002, 5'h01);
      send("tie_even",    1'b0, 10'sd127,  m_tie,  3'd0, 32'h3F800000, 5'h01);
      send("carry_out",   1'b0, 10'sd127,  m_ones, 3'd0, 32'h40000000, 5'h01);
      send("ovf_rne",     1'b0, 10'sd254,  m_top,  3'd0, 32'h7F800000, 5'h05);
      send("ovf_rtz",     1'b0, 10'sd254,  m_top,  3'd1, 32'h7F7FFFFF, 5'h05);
      send("ovf_rup_neg", 1'b1, 10'sd254,  m_top,  3'd3, 32'hFF7FFFFF, 5'h05);
      send("ovf_rdn_neg", 1'b1, 10'sd254,  m_top,  3'd2, 32'hFF800000, 5'h05);
      send("ovf_carry",   1'b0, 10'sd254,  m_ones, 3'd0, 32'h7F800000, 5'h05);
      send("sub_exact",   1'b0, -10'sd1,   m_one,  3'd0, 32'h00200000, 5'h00);
      send("sub_sticky",  1'b0, -10'sd1,   m_sub1, 3'd0, 32'h00200000, 5'h03);
      send("sub_to_norm", 1'b0, 10'sd0,    m_subn, 3'd0, 32'h00800000, 5'h03);
      send("deep_rne",    1'b0, -10'sd200, m_one,  3'd0, 32'h00000000, 5'h03);
      send("deep_rup",    1'b0, -10'sd200, m_one,  3'd3, 32'h00000001, 5'h03);
      send("zero_neg",    1'b1, 10'sd127,  '0,     3'd0, 32'h80000000, 5'h00);
      send("special",     1'b0, 10'sd127,  m_one,  3'd0, 32'h7FC00000, 5'h10,
           0, 1'b1, 32'h7FC00000, 5'h10);
      drain();

      // Backpressure: two beats fill the pipe, the third waits for out_ready.
      @(posedge clk); #1 out_ready = 1'b0;
      send("bp_a", 1'b0, 10'sd127, m_one, 3'd0, 32'h3F800000, 5'h00);
      send("bp_b", 1'b0, 10'sd127, m_r22, 3'd1, 32'h3F800001, 5'h01);
      @(negedge clk);
      chk("bp_in_ready_full", 64'(in_ready), 64'd0);
      fork
         send("bp_c", 1'b1, 10'sd127, m_r22, 3'd0, 32'hBF800002, 5'h01);
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two beats in flight: both must vanish.
      @(posedge clk); #1 out_ready = 1'b0;
      send("rst_a", 1'b0, 10'sd127, m_one, 3'd0, 32'h3F800000, 5'h00);
      send("rst_b", 1'b0, 10'sd127, m_r22, 3'd0, 32'h3F800002, 5'h01);
      @(posedge clk); #2 reset = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_rslt", 64'(rslt), 64'd0);
      chk("rst_flag", 64'(flag), 64'd0);
      sb.delete();
      @(negedge clk); #2 reset = 1'b1;
      @(posedge clk); #1 out_ready = 1'b1;
      stale = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) stale = 1;
      end
      chk("rst_no_stale", 64'(stale), 64'd0);
      send("post_rst", 1'b0, 10'sd127, m_one, 3'd0, 32'h3F800000, 5'h00, 1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fnorm_rnd.md
FNORM_RND -- requirements
Module: fnorm_rnd

Interface
REQ-001 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sign  in  1  result sign.
- in_exp  in  10  signed; a leading one at mag bit p gives biased exponent in_exp+p-80.
- in_mag  in  82  unsigned adder magnitude (downstream of add: {cout-extended addo}).
- in_rm  in  3  rounding mode: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4.
- in_spc  in  1  special result already resolved upstream (NaN/Inf/invalid).
- in_spc_val  in  32  special result word.
- in_spc_flag  in  5  special flags.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- rslt  out  32  IEEE single result.
- flag  out  5  {NV,DZ,OF,UF,NX}, bits 4..0.

Function
REQ-002 SHALL be a 2-stage pipeline: S1 = leading-zero count + normalize shift; S2 = round, pack, flags.
REQ-003 Latency SHALL be exactly 2 cycles from accepted beat (in_valid&in_ready) to out_valid when out_ready stays high; throughput 1 beat/cycle.
REQ-004 A stage SHALL load when it is empty or its contents advance in the same cycle; in_ready = !S1_valid | S1_advance.
REQ-005 A beat SHALL be held stable on rslt/flag while out_valid & !out_ready; no beat lost, duplicated or reordered.
REQ-006 Simultaneous accept and emit in a full pipeline SHALL sustain full rate with no bubble.
REQ-007 S1 SHALL compute p = leading-one position, e = in_exp+p-80, and left-justify mag so the leading one sits at bit 81.
REQ-008 If e <= 0, S1 SHALL right-shift by 1-e (saturate at 82), set biased exponent 0, and OR every shifted-out bit into sticky.
REQ-009 S2 SHALL take 24-bit significand (bits 81:58), guard = bit 57, sticky = OR(56:0) | S1 sticky.
REQ-010 Rounding: RNE up if g&(s|lsb); RTZ never; RDN up if (g|s)&sign; RUP up if (g|s)&!sign; RMM up if g.
REQ-011 Significand carry-out on round-up SHALL increment exponent and renormalize; subnormal rounding into 0x800000 SHALL yield exponent 1.
REQ-012 Exponent >= 255 after rounding SHALL set OF|NX and produce Inf for RNE/RMM, for RUP when positive, for RDN when negative; otherwise max finite 0x7F7FFFFF with sign.
REQ-013 NX SHALL be g|s; UF SHALL be set when result is tiny before rounding (e <= 0) and NX.
REQ-014 in_mag == 0 SHALL produce signed zero with in_sign, flag 0.
REQ-015 in_spc SHALL bypass arithmetic: rslt = in_spc_val, flag = in_spc_flag, same 2-cycle latency.
REQ-016 NV and DZ SHALL only originate from in_spc_flag.

Reset
REQ-017 reset low SHALL asynchronously clear both stage valids; out_valid=0, in_ready=1, rslt=0, flag=0.
REQ-018 Beats in flight at reset assertion SHALL be discarded; the first beat after reset release behaves as from idle.

Structure
REQ-019 Rounding-mode encodings, flag bit positions, and normit/normot structs (matching the mulit/addit style) SHALL live in the shared fma package.
REQ-020 Leading-zero count SHALL be a sub-module lzc82 (82-bit in, 7-bit count, zero flag), combinational, instantiated in S1.

Verification
REQ-021 mag=1<<80, exp=127, sign=0, RNE -> rslt 0x3F800000, flag 0x00, out_valid exactly 2 cycles after accept.
REQ-022 mag=(0x800001<<57)|(1<<56), exp=127, RNE -> 0x3F800002, flag 0x01; same input RTZ -> 0x3F800001, flag 0x01.
REQ-023 mag=1<<81, exp=254: RNE -> 0x7F800000, flag 0x05; RTZ -> 0x7F7FFFFF, flag 0x05.
REQ-024 mag=1<<80, exp=-1, RNE -> 0x00200000, flag 0x00; mag=(1<<80)|1, exp=-1 -> 0x00200000, flag 0x03.
REQ-025 Three back-to-back beats with out_ready low 4 cycles -> in_ready drops after 2 accepted; all 3 emerge in order, unchanged, once out_ready rises.
REQ-026 reset pulsed low with 2 beats in flight -> out_valid falls immediately, no stale beat emitted after release.
